// File: rtl/interboard_receiver.sv
// Receiver side of the 4-phase interboard link: synchronizes Request_in, acknowledges
// each word and assembles {header, number} frames into one-cycle message or reset pulses.
module interboard_receiver #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Request_in,
  input  logic [5:0] inter_data_in,
  output logic       Ack_out,
  output logic       interboard_en,
  output logic [2:0] interboard_msg_type,
  output logic [4:0] interboard_number,
  output logic       interboard_rst,
  output logic       rx_busy,
  output logic       rx_error
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [2:0]       TYPE_RESET = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    ACK_HDR,
    WAIT_NUM,
    ACK_NUM,
    DONE
  } state_t;

  state_t           state, state_nx;
  logic             req_m, req_s;
  logic [2:0]       hdr_type, hdr_nx;
  logic [4:0]       num_q, num_nx;
  logic             discard, discard_nx;
  logic [CNT_W-1:0] cnt;
  logic             err_nx;
  logic             ack_nx;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_nx   = state;
    hdr_nx     = hdr_type;
    num_nx     = num_q;
    discard_nx = discard;
    err_nx     = 1'b0;
    unique case (state)
      IDLE: begin
        // Skipping the cycle right after a timeout pulse keeps rx_error to single-cycle pulses.
        if (req_s && !rx_error) begin
          state_nx = ACK_HDR;
          if (inter_data_in[5]) begin
            hdr_nx     = inter_data_in[2:0];
            discard_nx = 1'b0;
          end else begin
            err_nx     = 1'b1;
            discard_nx = 1'b1;
          end
        end
      end
      ACK_HDR: begin
        if (!req_s) state_nx = discard ? IDLE : WAIT_NUM;
      end
      WAIT_NUM: begin
        if (req_s) begin
          if (inter_data_in[5]) begin
            err_nx     = 1'b1;
            hdr_nx     = inter_data_in[2:0];
            discard_nx = 1'b0;
            state_nx   = ACK_HDR;
          end else begin
            num_nx   = inter_data_in[4:0];
            state_nx = ACK_NUM;
          end
        end else if (cnt >= CNT_LAST) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end
      end
      ACK_NUM: begin
        if (!req_s) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign ack_nx  = (state_nx == ACK_HDR) || (state_nx == ACK_NUM);
  assign rx_busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_m               <= 1'b0;
      req_s               <= 1'b0;
      state               <= IDLE;
      hdr_type            <= '0;
      num_q               <= '0;
      discard             <= 1'b0;
      cnt                 <= '0;
      Ack_out             <= 1'b0;
      rx_error            <= 1'b0;
      interboard_en       <= 1'b0;
      interboard_rst      <= 1'b0;
      interboard_msg_type <= '0;
      interboard_number   <= '0;
    end else begin
      req_m          <= Request_in;
      req_s          <= req_m;
      state          <= state_nx;
      hdr_type       <= hdr_nx;
      num_q          <= num_nx;
      discard        <= discard_nx;
      Ack_out        <= ack_nx;
      rx_error       <= err_nx;
      interboard_en  <= 1'b0;
      interboard_rst <= 1'b0;
      // Held at zero outside WAIT_NUM, so it is already clear on entry; saturates at all-ones.
      if (state != WAIT_NUM)  cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      if (state == DONE) begin
        if (hdr_type == TYPE_RESET) begin
          interboard_rst <= 1'b1;
        end else begin
          interboard_en       <= 1'b1;
          interboard_msg_type <= hdr_type;
          interboard_number   <= num_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_interboard_receiver.sv
// Randomized bench for interboard_receiver: a word-level protocol model predicts pulse
// counts and the last valid message; a monitor counts pulses and checks their shape.
module tb_interboard_receiver;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       Request_in;
  logic [5:0] inter_data_in;
  logic       Ack_out;
  logic       interboard_en;
  logic [2:0] interboard_msg_type;
  logic [4:0] interboard_number;
  logic       interboard_rst;
  logic       rx_busy;
  logic       rx_error;

  interboard_receiver #(.TIMEOUT_CYCLES(TO)) dut (
    .clk                 (clk),
    .rst                 (rst_n),
    .Request_in          (Request_in),
    .inter_data_in       (inter_data_in),
    .Ack_out             (Ack_out),
    .interboard_en       (interboard_en),
    .interboard_msg_type (interboard_msg_type),
    .interboard_number   (interboard_number),
    .interboard_rst      (interboard_rst),
    .rx_busy             (rx_busy),
    .rx_error            (rx_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: pulse counters and pulse-shape rules
  int   en_cnt = 0, rstp_cnt = 0, err_cnt = 0, ack_rise = 0;
  logic prev_en = 0, prev_rstp = 0, prev_err = 0, prev_ack = 0;

  always @(negedge clk) begin
    if (interboard_en) begin
      en_cnt <= en_cnt + 1;
      check("en_one_cycle", prev_en, 1'b0);
      check("en_rst_exclusive", interboard_rst, 1'b0);
    end
    if (interboard_rst) begin
      rstp_cnt <= rstp_cnt + 1;
      check("rst_one_cycle", prev_rstp, 1'b0);
    end
    if (rx_error) begin
      err_cnt <= err_cnt + 1;
      check("err_one_cycle", prev_err, 1'b0);
    end
    if (Ack_out && !prev_ack) ack_rise <= ack_rise + 1;
    prev_en   <= interboard_en;
    prev_rstp <= interboard_rst;
    prev_err  <= rx_error;
    prev_ack  <= Ack_out;
  end

  // Word-level reference model
  int         exp_en = 0, exp_rstp = 0, exp_err = 0, exp_ack = 0;
  logic [2:0] exp_type = 0;
  logic [4:0] exp_num  = 0;
  logic [2:0] m_hdr    = 0;
  bit         expect_num = 0;

  task automatic model_word(input logic [5:0] w);
    exp_ack++;
    if (!expect_num) begin
      if (w[5]) begin
        m_hdr = w[2:0];
        expect_num = 1;
      end else begin
        exp_err++;
      end
    end else if (w[5]) begin
      exp_err++;
      m_hdr = w[2:0];
    end else begin
      expect_num = 0;
      if (m_hdr == 3'd7) exp_rstp++;
      else begin
        exp_en++;
        exp_type = m_hdr;
        exp_num  = w[4:0];
      end
    end
  endtask

  task automatic model_timeout();
    if (expect_num) begin
      exp_err++;
      expect_num = 0;
    end
  endtask

  task automatic model_reset();
    expect_num = 0;
    exp_type   = 0;
    exp_num    = 0;
  endtask

  task automatic compare(input string tag);
    #1;
    check({tag, "_en_count"}, en_cnt, exp_en);
    check({tag, "_rst_count"}, rstp_cnt, exp_rstp);
    check({tag, "_err_count"}, err_cnt, exp_err);
    check({tag, "_ack_count"}, ack_rise, exp_ack);
    check({tag, "_msg_type"}, interboard_msg_type, exp_type);
    check({tag, "_number"}, interboard_number, exp_num);
    check({tag, "_busy"}, rx_busy, expect_num);
  endtask

  task automatic wait_ack(input logic v);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (Ack_out === v) return;
    end
    check("ack_wait_timeout", Ack_out, v);
  endtask

  task automatic send_word(input logic [5:0] w, input int hold);
    @(negedge clk);
    inter_data_in = w;
    Request_in    = 1'b1;
    wait_ack(1'b1);
    repeat (hold) @(negedge clk);
    Request_in = 1'b0;
    wait_ack(1'b0);
  endtask

  task automatic do_word(input logic [5:0] w, input string tag);
    send_word(w, $urandom_range(0, 3));
    model_word(w);
    repeat (3 + $urandom_range(0, 3)) @(negedge clk);
    compare(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_err;
    int en0, ack0;

    rst_n = 1'b0;
    Request_in = 1'b0;
    inter_data_in = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ack", Ack_out, 0);
    check("reset_en", interboard_en, 0);
    check("reset_rst", interboard_rst, 0);
    check("reset_err", rx_error, 0);
    check("reset_busy", rx_busy, 0);
    check("reset_type", interboard_msg_type, 0);
    check("reset_number", interboard_number, 0);
    rst_n = 1'b1;

    // Valid frame type 2, number 23, two Ack pulses
    en0 = exp_en; ack0 = ack_rise;
    do_word(6'b100_010, "valid_hdr");
    do_word(6'b0_10111, "valid_num");
    check("valid_type", interboard_msg_type, 3'b010);
    check("valid_number", interboard_number, 5'd23);
    check("valid_ack_pulses", ack_rise - ack0, 2);
    check("valid_en_pulses", en_cnt - en0, 1);

    // RESET frame leaves message outputs unchanged
    do_word(6'b100_111, "rstf_hdr");
    do_word(6'b0_00000, "rstf_num");
    check("rstf_type_kept", interboard_msg_type, 3'b010);
    check("rstf_number_kept", interboard_number, 5'd23);

    // Timeout: header then idle, error exactly TO cycles into WAIT_NUM
    send_word(6'b111_001, 0);
    model_word(6'b111_001);
    first_err = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rx_error && first_err == 0) first_err = i;
    end
    model_timeout();
    check("timeout_latency", first_err, TO);
    compare("timeout");
    do_word(6'b100_110, "after_to_hdr");
    do_word(6'b0_00001, "after_to_num");

    // Resync on a second header
    do_word(6'b100_001, "resync_hdr1");
    do_word(6'b100_011, "resync_hdr2");
    do_word(6'b0_00101, "resync_num");
    check("resync_type", interboard_msg_type, 3'b011);
    check("resync_number", interboard_number, 5'd5);

    // Stray number word in IDLE
    do_word(6'b0_01010, "stray");

    // Reset while Ack_out is high in ACK_NUM
    do_word(6'b100_100, "midrst_hdr");
    @(negedge clk);
    inter_data_in = 6'b0_00011;
    Request_in = 1'b1;
    wait_ack(1'b1);
    #1;
    check("midrst_busy_before", rx_busy, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_ack_async", Ack_out, 0);
    check("midrst_busy", rx_busy, 0);
    check("midrst_en", interboard_en, 0);
    check("midrst_type", interboard_msg_type, 0);
    check("midrst_number", interboard_number, 0);
    exp_ack++;
    model_reset();
    Request_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    compare("midrst_after");

    // Request_in already high when reset releases is taken as a new word
    @(negedge clk);
    rst_n = 1'b0;
    inter_data_in = 6'b100_101;
    Request_in = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ack(1'b1);
    Request_in = 1'b0;
    wait_ack(1'b0);
    model_word(6'b100_101);
    repeat (3) @(negedge clk);
    compare("held_req_hdr");
    do_word(6'b0_01100, "held_req_num");

    // Randomized word stream
    for (int s = 0; s < 80; s++) begin
      int r;
      logic [5:0] w;
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        w = {1'b1, 5'($urandom_range(0, 31))};
        do_word(w, "rand_hdr");
      end else if (r <= 8) begin
        w = {1'b0, 5'($urandom_range(0, 31))};
        do_word(w, "rand_num");
      end else begin
        repeat (20) @(negedge clk);
        model_timeout();
        compare("rand_idle");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
